// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   mdu_op_e    : operation encodings carried on the op bus
//   mdu_state_e : sequencer states
//   MDU_WIDTH   : default operand width
//   MDU_CNT_W   : step counter width for the default operand width
package mdu_pkg;

   typedef enum logic [1:0] {
      MDU_MUL  = 2'b00,
      MDU_MULH = 2'b01,
      MDU_DIV  = 2'b10,
      MDU_REM  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIN  = 2'd2
   } mdu_state_e;

   localparam int MDU_WIDTH = 16;

   // One extra bit so the counter can hold WIDTH itself.
   function automatic int mdu_cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

   localparam int MDU_CNT_W = mdu_cnt_width(MDU_WIDTH);

   function automatic logic is_div_op(input mdu_op_e op);
      return (op == MDU_DIV) || (op == MDU_REM);
   endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the main controller and the multiply/divide unit.
//   master (controller) drives : start, flush, op, sgn, a, b
//   slave  (mdu)        drives : busy, done, result, div_by_zero
interface mdu_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             flush;
   logic [1:0]       op;
   logic             sgn;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             div_by_zero;

   modport master (
      output start, flush, op, sgn, a, b,
      input  busy, done, result, div_by_zero
   );

   modport slave (
      input  start, flush, op, sgn, a, b,
      output busy, done, result, div_by_zero
   );
endinterface

// File: rtl/mdu_datapath.sv
// Radix-2 shift-add / restoring shift-subtract datapath.
// Build option: MDU_SIGNED_EN adds magnitude conversion of operands at load and
// sign correction of the final values; without it sgn is ignored.
// Ports:
//   clk, rst        clock, async active-high reset
//   load            capture operands (first cycle of a new operation)
//   step            perform one iteration
//   div_mode        1 = restoring divide step, 0 = shift-add multiply step
//   sgn, a, b       operands as presented at load
//   prod_lo/hi      product halves after the step in flight
//   quot, rem       quotient / remainder after the step in flight
// The outputs reflect the value the registers will hold after this cycle's step,
// so the sequencer can capture the final result on the same edge as the last step.
module mdu_datapath import mdu_pkg::*; #(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             div_mode,
   input  logic             sgn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem
);

   // acc holds product-high / partial remainder, sh holds product-low / quotient.
   logic [WIDTH-1:0]   acc_q, sh_q, dvs_q;
   logic [WIDTH-1:0]   acc_nxt, sh_nxt;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     sum, trial;
   logic [2*WIDTH-1:0] prod_mag, prod;

   assign sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, dvs_q} : {(WIDTH+1){1'b0}});
   // Partial remainder stays below the divisor, so the shifted value fits in WIDTH+1
   // bits and trial[WIDTH] is the borrow.
   assign trial = {acc_q, sh_q[WIDTH-1]} - {1'b0, dvs_q};

   always_comb begin
      if (div_mode) begin
         acc_nxt = trial[WIDTH] ? {acc_q[WIDTH-2:0], sh_q[WIDTH-1]} : trial[WIDTH-1:0];
         sh_nxt  = {sh_q[WIDTH-2:0], ~trial[WIDTH]};
      end else begin
         acc_nxt = sum[WIDTH:1];
         sh_nxt  = {sum[0], sh_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         sh_q  <= '0;
         dvs_q <= '0;
      end else if (load) begin
         acc_q <= '0;
         sh_q  <= a_mag;
         dvs_q <= b_mag;
      end else if (step) begin
         acc_q <= acc_nxt;
         sh_q  <= sh_nxt;
      end
   end

   assign prod_mag = {acc_nxt, sh_nxt};

`ifdef MDU_SIGNED_EN
   logic neg_a_q, neg_b_q;

   assign a_mag = (sgn && a[WIDTH-1]) ? (~a + 1'b1) : a;
   assign b_mag = (sgn && b[WIDTH-1]) ? (~b + 1'b1) : b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
      end else if (load) begin
         neg_a_q <= sgn & a[WIDTH-1];
         neg_b_q <= sgn & b[WIDTH-1];
      end
   end

   // Remainder takes the dividend's sign; product and quotient take a^b.
   assign prod = (neg_a_q ^ neg_b_q) ? (~prod_mag + 1'b1) : prod_mag;
   assign quot = (neg_a_q ^ neg_b_q) ? (~sh_nxt + 1'b1) : sh_nxt;
   assign rem  = neg_a_q ? (~acc_nxt + 1'b1) : acc_nxt;
`else
   logic unused_sgn;
   assign unused_sgn = sgn;

   assign a_mag = a;
   assign b_mag = b;
   assign prod  = prod_mag;
   assign quot  = sh_nxt;
   assign rem   = acc_nxt;
`endif

   assign prod_lo = prod[WIDTH-1:0];
   assign prod_hi = prod[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit: sequencing FSM, step counter, handshake outputs
// and result selection around mdu_datapath.
// Build option: MDU_SIGNED_EN enables signed operation when sgn=1 (see mdu_datapath).
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   mdu_sequencer_if.slave: start/flush/op/sgn/a/b in, busy/done/result/div_by_zero out
//
// state  | meaning
// S_IDLE | waiting for start; result and div_by_zero hold the last outcome
// S_CALC | one datapath step per cycle, counter 0..WIDTH-1
// S_FIN  | done pulse, result valid; always returns to S_IDLE
module mdu_sequencer import mdu_pkg::*; #(
   parameter int WIDTH = MDU_WIDTH
) (
   input logic            clk,
   input logic            rst,
   mdu_sequencer_if.slave bus
);

   localparam int               CNT_W     = mdu_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   mdu_state_e       state;
   mdu_op_e          op_q, op_in;
   logic [CNT_W-1:0] cnt;
   logic             busy_q, done_q, dbz_q;
   logic [WIDTH-1:0] result_q, fin_result;
   logic             accept, dp_step, div_zero_in;
   logic [WIDTH-1:0] prod_lo, prod_hi, quot, rem;

   assign op_in       = mdu_op_e'(bus.op);
   assign accept      = (state == S_IDLE) && bus.start && !bus.flush;
   assign dp_step     = (state == S_CALC) && !bus.flush;
   assign div_zero_in = is_div_op(op_in) && (bus.b == '0);

   mdu_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .step     (dp_step),
      .div_mode (is_div_op(op_q)),
      .sgn      (bus.sgn),
      .a        (bus.a),
      .b        (bus.b),
      .prod_lo  (prod_lo),
      .prod_hi  (prod_hi),
      .quot     (quot),
      .rem      (rem)
   );

   always_comb begin
      fin_result = prod_lo;
      case (op_q)
         MDU_MUL:  fin_result = prod_lo;
         MDU_MULH: fin_result = prod_hi;
         MDU_DIV:  fin_result = quot;
         MDU_REM:  fin_result = rem;
         default:  fin_result = prod_lo;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         op_q     <= MDU_MUL;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.start) begin
                     op_q   <= op_in;
                     cnt    <= '0;
                     busy_q <= 1'b1;
                     dbz_q  <= 1'b0;
                     if (div_zero_in) begin
                        // No iterations needed: answer is fixed by the operation.
                        state    <= S_FIN;
                        done_q   <= 1'b1;
                        dbz_q    <= 1'b1;
                        result_q <= (op_in == MDU_DIV) ? '1 : bus.a;
                     end else begin
                        state <= S_CALC;
                     end
                  end
               end
               S_CALC: begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_STEP) begin
                     state    <= S_FIN;
                     done_q   <= 1'b1;
                     result_q <= fin_result;
                  end
               end
               S_FIN: begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
               default: begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.result      = result_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed vector table, multi-cycle
// handshake/flush/reset sequences, and randomized operations checked against an
// arithmetic reference model. Honors MDU_SIGNED_EN for the signed expectations.
module tb_mdu_sequencer;

   localparam int W = 16;
   localparam logic [1:0] OP_MUL = 2'b00, OP_MULH = 2'b01, OP_DIV = 2'b10, OP_REM = 2'b11;
`ifdef MDU_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   logic clk, rst;
   mdu_sequencer_if #(.WIDTH(W)) bus ();
   mdu_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  op;
      logic        sgn;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        dbz;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Reference: {div_by_zero, result} from plain integer arithmetic.
   function automatic logic [16:0] model(input logic [1:0] op, input logic sgn,
                                         input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p;
      int sa, sb;
      if (op[1] && b == 16'h0000)
         return {1'b1, (op == OP_DIV) ? 16'hFFFF : a};
      if (SIGNED_EN && sgn) begin
         sa = int'($signed(a));
         sb = int'($signed(b));
         p  = 32'(sa * sb);
         case (op)
            OP_MUL:  return {1'b0, p[15:0]};
            OP_MULH: return {1'b0, p[31:16]};
            OP_DIV:  return {1'b0, 16'(sa / sb)};
            default: return {1'b0, 16'(sa % sb)};
         endcase
      end
      p = 32'(a) * 32'(b);
      case (op)
         OP_MUL:  return {1'b0, p[15:0]};
         OP_MULH: return {1'b0, p[31:16]};
         OP_DIV:  return {1'b0, a / b};
         default: return {1'b0, a % b};
      endcase
   endfunction

   // Called at a negedge in IDLE. Returns at the negedge where done is seen (or budget out).
   task automatic run_op(input logic [1:0] op, input logic sgn, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] res, output logic dbz,
                         output int lat, output logic busy_ok);
      bus.op = op; bus.sgn = sgn; bus.a = a; bus.b = b; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      busy_ok = 1'b1;
      while (!bus.done && lat < 40) begin
         if (!bus.busy) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (!bus.busy) busy_ok = 1'b0;
      res = bus.result;
      dbz = bus.div_by_zero;
   endtask

   logic [15:0] got_res, ra, rb;
   logic        got_dbz, got_busy, rsgn;
   logic [1:0]  rop;
   logic [16:0] exp_m;
   int          got_lat, k, ndone;

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs.push_back('{OP_MUL,  1'b0, 16'h0123, 16'h0010, 16'h1230, 1'b0, 17});
      vecs.push_back('{OP_MULH, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 17});
      vecs.push_back('{OP_DIV,  1'b0, 16'd1000, 16'd7,    16'd142,  1'b0, 17});
      vecs.push_back('{OP_REM,  1'b0, 16'd1000, 16'd7,    16'd6,    1'b0, 17});
      vecs.push_back('{OP_DIV,  1'b0, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1});
      vecs.push_back('{OP_REM,  1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1});
      vecs.push_back('{OP_DIV,  1'b1, 16'hFFF9, 16'h0002, SIGNED_EN ? 16'hFFFD : 16'h7FFC, 1'b0, 17});
      vecs.push_back('{OP_REM,  1'b1, 16'hFFF9, 16'h0002, SIGNED_EN ? 16'hFFFF : 16'h0001, 1'b0, 17});
      vecs.push_back('{OP_DIV,  1'b1, 16'h8000, 16'hFFFF, SIGNED_EN ? 16'h8000 : 16'h0000, 1'b0, 17});
      vecs.push_back('{OP_REM,  1'b1, 16'h8000, 16'hFFFF, SIGNED_EN ? 16'h0000 : 16'h8000, 1'b0, 17});
      vecs.push_back('{OP_MUL,  1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 1'b0, 17});
      vecs.push_back('{OP_MULH, 1'b1, 16'hFFFD, 16'h0005, SIGNED_EN ? 16'hFFFF : 16'h0004, 1'b0, 17});
      vecs.push_back('{OP_DIV,  1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 1'b0, 17});
      vecs.push_back('{OP_MUL,  1'b0, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, 17});
      vecs.push_back('{OP_REM,  1'b0, 16'd5,    16'd9,    16'd5,    1'b0, 17});
      vecs.push_back('{OP_DIV,  1'b1, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1});

      rst = 1'b1;
      bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00; bus.sgn = 1'b0;
      bus.a = '0; bus.b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_result", bus.result, 0);
      check("rst_dbz", bus.div_by_zero, 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors, issued back-to-back (start in the IDLE cycle after FIN).
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, got_res, got_dbz, got_lat, got_busy);
         check($sformatf("vec%0d_result", i), got_res, vecs[i].res);
         check($sformatf("vec%0d_dbz", i), got_dbz, vecs[i].dbz);
         check($sformatf("vec%0d_latency", i), got_lat, vecs[i].lat);
         check($sformatf("vec%0d_busy", i), got_busy, 1);
         @(negedge clk);
         check($sformatf("vec%0d_done_pulse", i), bus.done, 0);
         check($sformatf("vec%0d_busy_clear", i), bus.busy, 0);
         check($sformatf("vec%0d_result_held", i), bus.result, vecs[i].res);
      end

      // start during CALC is ignored
      bus.op = OP_MUL; bus.sgn = 1'b0; bus.a = 16'h0123; bus.b = 16'h0010; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.op = OP_MULH; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      k = 6;
      while (!bus.done && k < 40) begin @(negedge clk); k++; end
      check("ign_latency", k, 17);
      check("ign_result", bus.result, 16'h1230);
      ndone = 0;
      repeat (25) begin @(negedge clk); if (bus.done) ndone++; end
      check("ign_extra_done", ndone, 0);
      check("ign_busy_clear", bus.busy, 0);

      // flush mid-CALC
      bus.op = OP_DIV; bus.a = 16'd1000; bus.b = 16'd7; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      check("flush_busy", bus.busy, 0);
      check("flush_done", bus.done, 0);
      ndone = 0;
      repeat (25) begin @(negedge clk); if (bus.done) ndone++; end
      check("flush_no_done", ndone, 0);
      check("flush_result_kept", bus.result, 16'h1230);

      run_op(OP_DIV, 1'b0, 16'd1000, 16'd7, got_res, got_dbz, got_lat, got_busy);
      check("post_flush_result", got_res, 16'd142);
      check("post_flush_latency", got_lat, 17);
      @(negedge clk);

      // start held high: not accepted in FIN, accepted in the following IDLE cycle
      bus.op = OP_DIV; bus.a = 16'd1000; bus.b = 16'd7; bus.start = 1'b1;
      @(negedge clk);
      k = 1;
      while (!bus.done && k < 40) begin @(negedge clk); k++; end
      check("held_first_latency", k, 17);
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.done && k < 40);
      bus.start = 1'b0;
      check("held_b2b_gap", k, 18);
      repeat (3) @(negedge clk);
      check("held_busy_clear", bus.busy, 0);

      // start and flush together in IDLE: flush wins
      bus.op = OP_MUL; bus.a = 16'h0003; bus.b = 16'h0005; bus.start = 1'b1; bus.flush = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      check("sf_busy", bus.busy, 0);
      ndone = 0;
      repeat (20) begin @(negedge clk); if (bus.done) ndone++; end
      check("sf_no_done", ndone, 0);
      check("sf_result_kept", bus.result, 16'd142);

      // async reset mid-CALC
      bus.op = OP_MUL; bus.a = 16'h0003; bus.b = 16'h0005; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_rst_busy", bus.busy, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", bus.busy, 0);
      check("arst_done", bus.done, 0);
      check("arst_result", bus.result, 0);
      check("arst_dbz", bus.div_by_zero, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // div_by_zero held in IDLE, cleared by async reset and by the next start
      run_op(OP_DIV, 1'b0, 16'h4321, 16'h0000, got_res, got_dbz, got_lat, got_busy);
      check("dz_result", got_res, 16'hFFFF);
      @(negedge clk);
      check("dz_held", bus.div_by_zero, 1);
      #3 rst = 1'b1;
      #1;
      check("dz_arst_dbz", bus.div_by_zero, 0);
      check("dz_arst_result", bus.result, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(OP_REM, 1'b0, 16'h4321, 16'h0000, got_res, got_dbz, got_lat, got_busy);
      check("dz2_result", got_res, 16'h4321);
      check("dz2_dbz", got_dbz, 1);
      @(negedge clk);
      bus.op = OP_MUL; bus.a = 16'h0011; bus.b = 16'h0011; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("dz_clear_on_start", bus.div_by_zero, 0);
      k = 1;
      while (!bus.done && k < 40) begin @(negedge clk); k++; end
      check("dz_clear_mul", bus.result, 16'h0121);
      @(negedge clk);

      // randomized operations against the reference model
      for (int n = 0; n < 150; n++) begin
         rop  = 2'($urandom_range(0, 3));
         rsgn = 1'($urandom_range(0, 1));
         ra   = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = 16'h0000;
            1:       rb = 16'($urandom_range(1, 15));
            2:       rb = 16'hFFFF;
            default: rb = 16'($urandom);
         endcase
         if ($urandom_range(0, 9) == 0) ra = 16'h8000;
         exp_m = model(rop, rsgn, ra, rb);
         run_op(rop, rsgn, ra, rb, got_res, got_dbz, got_lat, got_busy);
         check($sformatf("rnd%0d_op%0d_s%0d_a%0h_b%0h_result", n, rop, rsgn, ra, rb), got_res, exp_m[15:0]);
         check($sformatf("rnd%0d_dbz", n), got_dbz, exp_m[16]);
         check($sformatf("rnd%0d_latency", n), got_lat, exp_m[16] ? 1 : 17);
         @(negedge clk);
         check($sformatf("rnd%0d_done_pulse", n), bus.done, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
